el2_ic_data_banked: RTL and testbench
=====================================

// Module: el2_ic_data_banked
// PURPOSE
//  Parametrised I-cache data array for the EL2 IFU. Holds WAYS ways x DEPTH entries of 71-bit words (64b data + 7b check).
//  Serves one functional read per cycle: a 1-cycle array access, then the way is chosen by io_ic_rd_hit, with a premux bypass.
//  Checks each read in PAR or ECC-lite mode. Adds a power-on zero-init sequencer and a queued debug read/write port.
//  Sits between the IFU mem-ctl and the fetch aligner.
// PARAMETERS
//  WAYS     2    number of ways (1..8); one SRAM bank per way
//  DEPTH    256  entries per way (power of 2); AW = clog2(DEPTH)
//  ECC_MODE 0    0: parity mode, bits[67:64] = even parity of data 16b chunks 0..3, bits[70:68] ignored
//                1: ECC-lite mode, check bit i (0..6) = XOR of data[j] for all j with j%7==i
// PORTS
//  clock                  in   1        core clock
//  io_rst_l               in   1        async active-low reset
//  io_clk_override        in   1        force read-stage regs to capture every cycle
//  io_scan_mode           in   1        scan; functionally ignored
//  io_ic_rw_addr          in   AW       functional read/write index
//  io_ic_wr_en            in   WAYS     per-way write enable
//  io_ic_wr_data          in   71*WAYS  write word per way, way w at [71w+70:71w]
//  io_ic_rd_en            in   1        functional read request
//  io_ic_rd_hit           in   WAYS     one-hot hit way, sampled in the cycle after rd_en
//  io_ic_premux_data      in   64       bypass fetch data
//  io_ic_sel_premux_data  in   1        select bypass data
//  io_ic_rd_data          out  64       selected read data
//  io_ic_parerr           out  WAYS     per-way parity error (ECC_MODE=0)
//  io_ic_eccerr           out  WAYS     per-way check error (ECC_MODE=1)
//  io_ic_debug_addr       in   AW       debug index
//  io_ic_debug_way        in   WAYS     debug way, one-hot
//  io_ic_debug_rd_en      in   1        debug read request (1-cycle pulse)
//  io_ic_debug_wr_en      in   1        debug write request (1-cycle pulse)
//  io_ic_debug_tag_array  in   1        1 = request targets the tag array; ignored here
//  io_ic_debug_wr_data    in   71       debug write word
//  io_ic_debug_rd_data    out  71       debug read word, held until the next debug read
//  io_ic_debug_rd_valid   out  1        1-cycle pulse when io_ic_debug_rd_data updates
//  io_ic_init_busy        out  1        high while the array is being zero-initialised
// BEHAVIOUR
//  Reset values: all outputs 0, except io_ic_init_busy=1. FSM enters INIT with init counter = 0.
//  FSM states:
//   INIT: write 71'h0 to entry cnt in all ways; cnt++. At cnt==DEPTH-1, go to IDLE next cycle.
//         Functional and debug requests are dropped, not queued. Init takes DEPTH cycles.
//   IDLE: capture a debug request (rd or wr, with tag_array=0) into a 1-entry pending reg. Go to DBG_WAIT.
//         A debug request that arrives while the pending reg is full is dropped.
//   DBG_WAIT: issue the pending op in the first cycle with no functional rd_en and no wr_en.
//         Write -> IDLE. Read -> DBG_RD.
//   DBG_RD: array output is valid. Register it to io_ic_debug_rd_data and pulse debug_rd_valid in the next cycle. Go to IDLE.
//  Port priority per cycle: init > functional write > functional read > debug op.
//   A debug op is never lost once queued. It may wait without bound.
//  Read latency: rd_en at cycle N.
//   At N+1, rd_data = sel_premux ? premux_data : OR over w of (rd_hit[w] ? way_w[63:0] : 0).
//   Multi-hot rd_hit ORs the ways. Zero-hot rd_hit gives 0.
//  Error flags at N+1 are per way, for every way read, independent of rd_hit.
//   They are forced to 0 when sel_premux_data=1 or when no read was issued at N.
//   The flag for the inactive mode (eccerr when ECC_MODE=0, parerr when ECC_MODE=1) is tied to 0.
//  Same cycle write and read to one index: the write updates the array. The read returns the OLD word (read-before-write).
//  Read-stage regs hold their last value when rd_en=0, unless clk_override=1.
//   With clk_override=1 they capture every cycle; rd_data is still forced to 0 when no read was issued.
//  Reset asserted mid-operation: pending debug op discarded, outputs cleared, INIT restarts at cnt 0.
//   Array contents are not reset directly; INIT overwrites them.
// TESTING
//  1. Reset, DEPTH=256 -> init_busy high exactly 256 cycles. Then a read of any entry/way returns 0 with parerr=0.
//  2. Write way1 idx5 data 64'hDEAD_BEEF_0123_4567 with correct parity. rd_en idx5, rd_hit=2'b10 -> next cycle rd_data=64'hDEADBEEF01234567, parerr=0.
//  3. Same write with bit[64] flipped, then read -> parerr=2'b10 at N+1, rd_data unchanged. With sel_premux=1 -> rd_data=premux_data, parerr=0.
//  4. Debug rd idx5 way1 while rd_en is held high 3 cycles -> debug_rd_valid pulses 2 cycles after rd_en drops. debug_rd_data = the 71-bit word written.
//  5. Same-cycle wr_en=2'b01 and rd_en at idx9 -> read returns prior word. A read at N+1 returns the new word.
//  6. ECC_MODE=1: flip data bit 13 -> eccerr[w]=1 (check bit 6). Assert io_rst_l low during DBG_WAIT -> no debug_rd_valid, and INIT restarts.

Source files
------------

// File: rtl/el2_ic_data_banked_if.sv
// I-cache data array port bundle.
// Master drives requests, slave returns data.
interface el2_ic_data_banked_if #(
  parameter int WAYS = 2,
  parameter int AW   = 8
);
  logic                   io_clk_override;
  logic                   io_scan_mode;
  logic [AW-1:0]          io_ic_rw_addr;
  logic [WAYS-1:0]        io_ic_wr_en;
  logic [71*WAYS-1:0]     io_ic_wr_data;
  logic                   io_ic_rd_en;
  logic [WAYS-1:0]        io_ic_rd_hit;
  logic [63:0]            io_ic_premux_data;
  logic                   io_ic_sel_premux_data;
  logic [63:0]            io_ic_rd_data;
  logic [WAYS-1:0]        io_ic_parerr;
  logic [WAYS-1:0]        io_ic_eccerr;
  logic [AW-1:0]          io_ic_debug_addr;
  logic [WAYS-1:0]        io_ic_debug_way;
  logic                   io_ic_debug_rd_en;
  logic                   io_ic_debug_wr_en;
  logic                   io_ic_debug_tag_array;
  logic [70:0]            io_ic_debug_wr_data;
  logic [70:0]            io_ic_debug_rd_data;
  logic                   io_ic_debug_rd_valid;
  logic                   io_ic_init_busy;

  modport master (
    output io_clk_override, io_scan_mode,
    output io_ic_rw_addr, io_ic_wr_en, io_ic_wr_data,
    output io_ic_rd_en, io_ic_rd_hit,
    output io_ic_premux_data, io_ic_sel_premux_data,
    output io_ic_debug_addr, io_ic_debug_way,
    output io_ic_debug_rd_en, io_ic_debug_wr_en,
    output io_ic_debug_tag_array, io_ic_debug_wr_data,
    input  io_ic_rd_data, io_ic_parerr, io_ic_eccerr,
    input  io_ic_debug_rd_data, io_ic_debug_rd_valid,
    input  io_ic_init_busy
  );

  modport slave (
    input  io_clk_override, io_scan_mode,
    input  io_ic_rw_addr, io_ic_wr_en, io_ic_wr_data,
    input  io_ic_rd_en, io_ic_rd_hit,
    input  io_ic_premux_data, io_ic_sel_premux_data,
    input  io_ic_debug_addr, io_ic_debug_way,
    input  io_ic_debug_rd_en, io_ic_debug_wr_en,
    input  io_ic_debug_tag_array, io_ic_debug_wr_data,
    output io_ic_rd_data, io_ic_parerr, io_ic_eccerr,
    output io_ic_debug_rd_data, io_ic_debug_rd_valid,
    output io_ic_init_busy
  );
endinterface

// File: rtl/el2_ic_data_banked.sv
// EL2 I-cache banked data array with zero-init,
// parity / ECC-lite check and queued debug port.
module el2_ic_data_banked #(
  parameter int WAYS     = 2,
  parameter int DEPTH    = 256,
  parameter int ECC_MODE = 0
) (
  input logic clock,
  input logic io_rst_l,
  el2_ic_data_banked_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    INIT, IDLE, DBG_WAIT, DBG_RD
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt;
  logic            pend_rd;
  logic [AW-1:0]   pend_addr;
  logic [WAYS-1:0] pend_way;
  logic [70:0]     pend_data;

  logic [70:0]     mem [WAYS][DEPTH];
  logic [70:0]     dout [WAYS];
  logic [WAYS-1:0] we;
  logic [AW-1:0]   waddr;
  logic [70:0]     wdata [WAYS];
  logic            re;
  logic [AW-1:0]   raddr;
  logic            rd_vq;
  logic            run;
  logic            dbg_req;
  logic            bus_busy;
  logic [63:0]     hit_data;
  logic [WAYS-1:0] par_err;
  logic [WAYS-1:0] ecc_err;
  logic [70:0]     dbg_sel;
  logic [70:0]     dbg_rd_data;
  logic            dbg_valid;
  logic            gate;
  logic            unused_scan;

  assign unused_scan = bus.io_scan_mode;

  function automatic logic bad_par(
    input logic [67:0] v
  );
    logic e;
    e = 1'b0;
    for (int i = 0; i < 4; i++)
      e |= (^v[16*i +: 16]) ^ v[64+i];
    return e;
  endfunction

  function automatic logic bad_ecc(
    input logic [70:0] v
  );
    logic e;
    logic x;
    e = 1'b0;
    for (int i = 0; i < 7; i++) begin
      x = v[64+i];
      for (int j = 0; j < 64; j++)
        if (j % 7 == i) x ^= v[j];
      e |= x;
    end
    return e;
  endfunction

  assign run = (state != INIT);
  assign dbg_req = (bus.io_ic_debug_rd_en |
                    bus.io_ic_debug_wr_en) &
                   ~bus.io_ic_debug_tag_array;
  assign bus_busy = bus.io_ic_rd_en |
                    (|bus.io_ic_wr_en);

  // State register; reset restarts init
  always_ff @(posedge clock or negedge io_rst_l) begin
    if (!io_rst_l) state <= INIT;
    else           state <= state_nxt;
  end

  // Next state and array port arbitration
  always_comb begin
    state_nxt = state;
    we        = '0;
    re        = 1'b0;
    waddr     = bus.io_ic_rw_addr;
    raddr     = bus.io_ic_rw_addr;
    for (int w = 0; w < WAYS; w++)
      wdata[w] = bus.io_ic_wr_data[71*w +: 71];
    if (run) begin
      we = bus.io_ic_wr_en;
      re = bus.io_ic_rd_en;
    end
    unique case (state)
      INIT: begin
        we    = '1;
        waddr = cnt;
        for (int w = 0; w < WAYS; w++)
          wdata[w] = '0;
        if (cnt == AW'(DEPTH-1))
          state_nxt = IDLE;
      end
      IDLE: begin
        if (dbg_req) state_nxt = DBG_WAIT;
      end
      DBG_WAIT: begin
        if (!bus_busy) begin
          if (pend_rd) begin
            re        = 1'b1;
            raddr     = pend_addr;
            state_nxt = DBG_RD;
          end else begin
            we    = pend_way;
            waddr = pend_addr;
            for (int w = 0; w < WAYS; w++)
              wdata[w] = pend_data;
            state_nxt = IDLE;
          end
        end
      end
      DBG_RD: state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // Array write port
  always_ff @(posedge clock) begin
    for (int w = 0; w < WAYS; w++)
      if (we[w]) mem[w][waddr] <= wdata[w];
  end

  // Read stage: old word seen on same-index write
  always_ff @(posedge clock or negedge io_rst_l) begin
    if (!io_rst_l) begin
      for (int w = 0; w < WAYS; w++)
        dout[w] <= '0;
    end else if (re | bus.io_clk_override) begin
      for (int w = 0; w < WAYS; w++)
        dout[w] <= mem[w][raddr];
    end
  end

  // Flag marking a functional read in the previous cycle
  always_ff @(posedge clock or negedge io_rst_l) begin
    if (!io_rst_l) rd_vq <= 1'b0;
    else           rd_vq <= run & bus.io_ic_rd_en;
  end

  // Init index counter
  always_ff @(posedge clock or negedge io_rst_l) begin
    if (!io_rst_l)          cnt <= '0;
    else if (state == INIT) cnt <= cnt + 1'b1;
  end

  // Way select and per-way checks
  always_comb begin
    hit_data = '0;
    par_err  = '0;
    ecc_err  = '0;
    dbg_sel  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (bus.io_ic_rd_hit[w])
        hit_data |= dout[w][63:0];
      if (pend_way[w])
        dbg_sel |= dout[w];
      par_err[w] = bad_par(dout[w][67:0]);
      ecc_err[w] = bad_ecc(dout[w]);
    end
  end

  assign gate = rd_vq & ~bus.io_ic_sel_premux_data;

  assign bus.io_ic_rd_data =
    !rd_vq ? '0 :
    bus.io_ic_sel_premux_data ?
      bus.io_ic_premux_data : hit_data;

  assign bus.io_ic_parerr =
    (ECC_MODE == 0 && gate) ? par_err : '0;
  assign bus.io_ic_eccerr =
    (ECC_MODE == 1 && gate) ? ecc_err : '0;

  // Debug pending slot and read return
  always_ff @(posedge clock or negedge io_rst_l) begin
    if (!io_rst_l) begin
      pend_rd     <= 1'b0;
      pend_addr   <= '0;
      pend_way    <= '0;
      pend_data   <= '0;
      dbg_rd_data <= '0;
      dbg_valid   <= 1'b0;
    end else begin
      dbg_valid <= 1'b0;
      if (state == IDLE && dbg_req) begin
        pend_rd   <= ~bus.io_ic_debug_wr_en;
        pend_addr <= bus.io_ic_debug_addr;
        pend_way  <= bus.io_ic_debug_way;
        pend_data <= bus.io_ic_debug_wr_data;
      end
      if (state == DBG_RD) begin
        dbg_rd_data <= dbg_sel;
        dbg_valid   <= 1'b1;
      end
    end
  end

  assign bus.io_ic_debug_rd_data  = dbg_rd_data;
  assign bus.io_ic_debug_rd_valid = dbg_valid;
  assign bus.io_ic_init_busy      = (state == INIT);
endmodule

// File: tb/tb_el2_ic_data_banked.sv
// Bench for el2_ic_data_banked: parity and
// ECC-lite instances on shared stimulus.
module tb_el2_ic_data_banked;
  localparam int WAYS = 2;
  localparam int DEPTH = 256;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  el2_ic_data_banked_if #(.WAYS(WAYS), .AW(AW)) bp();
  el2_ic_data_banked_if #(.WAYS(WAYS), .AW(AW)) be();

  assign be.io_clk_override = bp.io_clk_override;
  assign be.io_scan_mode = bp.io_scan_mode;
  assign be.io_ic_rw_addr = bp.io_ic_rw_addr;
  assign be.io_ic_wr_en = bp.io_ic_wr_en;
  assign be.io_ic_wr_data = bp.io_ic_wr_data;
  assign be.io_ic_rd_en = bp.io_ic_rd_en;
  assign be.io_ic_rd_hit = bp.io_ic_rd_hit;
  assign be.io_ic_premux_data = bp.io_ic_premux_data;
  assign be.io_ic_sel_premux_data = bp.io_ic_sel_premux_data;
  assign be.io_ic_debug_addr = bp.io_ic_debug_addr;
  assign be.io_ic_debug_way = bp.io_ic_debug_way;
  assign be.io_ic_debug_rd_en = bp.io_ic_debug_rd_en;
  assign be.io_ic_debug_wr_en = bp.io_ic_debug_wr_en;
  assign be.io_ic_debug_tag_array = bp.io_ic_debug_tag_array;
  assign be.io_ic_debug_wr_data = bp.io_ic_debug_wr_data;

  el2_ic_data_banked #(
    .WAYS(WAYS), .DEPTH(DEPTH), .ECC_MODE(0)
  ) dut_par (
    .clock(clk), .io_rst_l(rst_l), .bus(bp)
  );

  el2_ic_data_banked #(
    .WAYS(WAYS), .DEPTH(DEPTH), .ECC_MODE(1)
  ) dut_ecc (
    .clock(clk), .io_rst_l(rst_l), .bus(be)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [70:0] mm [WAYS][DEPTH];
  logic        pend;
  logic [70:0] snap [WAYS];
  logic [63:0] exp_rd;
  logic [1:0]  exp_par;
  logic [1:0]  exp_ecc;

  typedef struct {
    logic [7:0]  addr;
    logic [1:0]  wr;
    logic [70:0] word;
    logic [1:0]  hit;
    logic        sel;
    logic [63:0] pm;
    logic [63:0] exp_rd;
    logic [1:0]  exp_par;
  } vec_t;

  vec_t tv [8];

  function automatic logic [3:0] par_bits(
    input logic [63:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^d[16*i +: 16];
    return p;
  endfunction

  function automatic logic [6:0] ecc_bits(
    input logic [63:0] d);
    logic [6:0] c;
    c = '0;
    for (int j = 0; j < 64; j++) c[j % 7] ^= d[j];
    return c;
  endfunction

  function automatic logic [70:0] par_word(
    input logic [63:0] d);
    return {3'b000, par_bits(d), d};
  endfunction

  function automatic logic [70:0] ecc_word(
    input logic [63:0] d);
    return {ecc_bits(d), d};
  endfunction

  function automatic logic par_bad(input logic [70:0] x);
    return x[67:64] != par_bits(x[63:0]);
  endfunction

  function automatic logic ecc_bad(input logic [70:0] x);
    return x[70:64] != ecc_bits(x[63:0]);
  endfunction

  function automatic logic [70:0] rnd_word();
    logic [63:0] d;
    d = {$urandom, $urandom};
    case ($urandom_range(0, 2))
      0: return par_word(d);
      1: return ecc_word(d);
      default: return {7'($urandom), d};
    endcase
  endfunction

  task automatic check(input string nm,
                       input logic [70:0] act,
                       input logic [70:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  task automatic model_clear();
    for (int w = 0; w < WAYS; w++)
      for (int i = 0; i < DEPTH; i++) mm[w][i] = '0;
    pend = 1'b0;
  endtask

  task automatic zero_inputs();
    bp.io_clk_override = 0;
    bp.io_scan_mode = 0;
    bp.io_ic_rw_addr = '0;
    bp.io_ic_wr_en = '0;
    bp.io_ic_wr_data = '0;
    bp.io_ic_rd_en = 0;
    bp.io_ic_rd_hit = '0;
    bp.io_ic_premux_data = '0;
    bp.io_ic_sel_premux_data = 0;
    bp.io_ic_debug_addr = '0;
    bp.io_ic_debug_way = '0;
    bp.io_ic_debug_rd_en = 0;
    bp.io_ic_debug_wr_en = 0;
    bp.io_ic_debug_tag_array = 0;
    bp.io_ic_debug_wr_data = '0;
  endtask

  // one cycle: drive, then predict outputs of prior read
  task automatic drive(input logic [1:0] wr,
                       input logic [7:0] addr,
                       input logic [70:0] w0,
                       input logic [70:0] w1,
                       input logic rd,
                       input logic [1:0] hit,
                       input logic sel,
                       input logic [63:0] pm,
                       input logic ovr);
    @(negedge clk);
    zero_inputs();
    bp.io_clk_override = ovr;
    bp.io_ic_rw_addr = addr;
    bp.io_ic_wr_en = wr;
    bp.io_ic_wr_data = {w1, w0};
    bp.io_ic_rd_en = rd;
    bp.io_ic_rd_hit = hit;
    bp.io_ic_sel_premux_data = sel;
    bp.io_ic_premux_data = pm;
    #1;
    exp_rd = '0;
    exp_par = '0;
    exp_ecc = '0;
    if (pend && sel) exp_rd = pm;
    else if (pend) begin
      for (int w = 0; w < WAYS; w++) begin
        if (hit[w]) exp_rd |= snap[w][63:0];
        exp_par[w] = par_bad(snap[w]);
        exp_ecc[w] = ecc_bad(snap[w]);
      end
    end
    pend = rd;
    if (rd)
      for (int w = 0; w < WAYS; w++) snap[w] = mm[w][addr];
    if (wr[0]) mm[0][addr] = w0;
    if (wr[1]) mm[1][addr] = w1;
  endtask

  task automatic idle_cyc();
    drive(2'b00, 8'd0, '0, '0, 1'b0, 2'b00, 1'b0, '0, 1'b0);
  endtask

  task automatic check_read(input string nm);
    check({nm, ".rd"}, 71'(bp.io_ic_rd_data), 71'(exp_rd));
    check({nm, ".par"}, 71'(bp.io_ic_parerr), 71'(exp_par));
    check({nm, ".p_ecc0"}, 71'(bp.io_ic_eccerr), 71'(0));
    check({nm, ".e_rd"}, 71'(be.io_ic_rd_data), 71'(exp_rd));
    check({nm, ".ecc"}, 71'(be.io_ic_eccerr), 71'(exp_ecc));
    check({nm, ".e_par0"}, 71'(be.io_ic_parerr), 71'(0));
  endtask

  // released at a negedge; count busy cycles and debug pulses
  task automatic count_init(output int n, output int v);
    n = 0;
    v = 0;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (bp.io_ic_debug_rd_valid) v++;
      if (!bp.io_ic_init_busy) break;
      n++;
      @(negedge clk);
    end
  endtask

  logic [63:0] d1;
  logic [70:0] w1;
  logic [70:0] wa;
  logic [70:0] wb;
  logic [70:0] xd;
  logic [70:0] wexp;
  int nb;
  int nv;
  int got;

  initial begin
    d1 = 64'hDEAD_BEEF_0123_4567;
    w1 = par_word(d1);
    tv[0] = '{8'd5, 2'b10, w1, 2'b10, 1'b0, 64'h0,
              d1, 2'b00};
    tv[1] = '{8'd5, 2'b10, w1 ^ (71'd1 << 64), 2'b10,
              1'b0, 64'h0, d1, 2'b10};
    tv[2] = '{8'd5, 2'b10, w1 ^ (71'd1 << 64), 2'b10,
              1'b1, 64'h1111_2222_3333_4444,
              64'h1111_2222_3333_4444, 2'b00};
    tv[3] = '{8'd7, 2'b01,
              par_word(64'hA5A5_A5A5_0000_FFFF), 2'b00,
              1'b0, 64'h0, 64'h0, 2'b00};
    tv[4] = '{8'd7, 2'b10,
              par_word(64'h0F0F_0000_1234_0001), 2'b11,
              1'b0, 64'h0, 64'hAFAF_A5A5_1234_FFFF, 2'b00};
    tv[5] = '{8'd200, 2'b01,
              par_word(64'h0123_4567_89AB_CDEF) ^
              (71'd1 << 70), 2'b01, 1'b0, 64'h0,
              64'h0123_4567_89AB_CDEF, 2'b00};
    tv[6] = '{8'd255, 2'b11,
              par_word(64'hFFFF_FFFF_FFFF_FFFF) ^
              (71'd1 << 66), 2'b01, 1'b0, 64'h0,
              64'hFFFF_FFFF_FFFF_FFFF, 2'b11};
    tv[7] = '{8'd100, 2'b00, 71'h0, 2'b11, 1'b0,
              64'h0, 64'h0, 2'b00};

    zero_inputs();
    model_clear();
    rst_l = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst.busy", 71'(bp.io_ic_init_busy), 71'(1));
    check("rst.rd", 71'(bp.io_ic_rd_data), 71'(0));
    check("rst.dvalid", 71'(bp.io_ic_debug_rd_valid), 71'(0));
    check("rst.ddata", bp.io_ic_debug_rd_data, 71'(0));
    check("rst.par", 71'(bp.io_ic_parerr), 71'(0));

    @(negedge clk);
    rst_l = 1'b1;
    count_init(nb, nv);
    check("init.cycles", 71'(nb), 71'(DEPTH));

    drive(2'b00, 8'd77, '0, '0, 1'b1, 2'b00, 1'b0, '0, 1'b0);
    drive(2'b00, 8'd0, '0, '0, 1'b0, 2'b11, 1'b0, '0, 1'b0);
    check_read("init.zero");

    for (int i = 0; i < 8; i++) begin
      drive(tv[i].wr, tv[i].addr, tv[i].word, tv[i].word,
            1'b0, 2'b00, 1'b0, '0, 1'b0);
      drive(2'b00, tv[i].addr, '0, '0, 1'b1, 2'b00,
            1'b0, '0, 1'b0);
      drive(2'b00, 8'd0, '0, '0, 1'b0, tv[i].hit,
            tv[i].sel, tv[i].pm, 1'b0);
      check($sformatf("tv%0d.rd", i),
            71'(bp.io_ic_rd_data), 71'(tv[i].exp_rd));
      check($sformatf("tv%0d.par", i),
            71'(bp.io_ic_parerr), 71'(tv[i].exp_par));
      check($sformatf("tv%0d.ecc", i),
            71'(be.io_ic_eccerr), 71'(exp_ecc));
    end

    drive(2'b00, 8'd0, '0, '0, 1'b0, 2'b11, 1'b0, '0, 1'b1);
    check("noread.rd", 71'(bp.io_ic_rd_data), 71'(0));
    check("noread.par", 71'(bp.io_ic_parerr), 71'(0));

    wa = par_word(64'h1111_0000_2222_0000);
    wb = par_word(64'h3333_4444_5555_6666);
    drive(2'b01, 8'd9, wa, '0, 1'b0, 2'b00, 1'b0, '0, 1'b0);
    drive(2'b01, 8'd9, wb, '0, 1'b1, 2'b00, 1'b0, '0, 1'b0);
    drive(2'b00, 8'd9, '0, '0, 1'b1, 2'b01, 1'b0, '0, 1'b0);
    check("rbw.old", 71'(bp.io_ic_rd_data),
          71'(64'h1111_0000_2222_0000));
    drive(2'b00, 8'd0, '0, '0, 1'b0, 2'b01, 1'b0, '0, 1'b0);
    check("rbw.new", 71'(bp.io_ic_rd_data),
          71'(64'h3333_4444_5555_6666));

    wa = ecc_word(64'h1357_9BDF_2468_ACE0) ^ (71'd1 << 13);
    wb = ecc_word(64'h1357_9BDF_2468_ACE0);
    drive(2'b11, 8'd30, wa, wb, 1'b0, 2'b00, 1'b0, '0, 1'b0);
    drive(2'b00, 8'd30, '0, '0, 1'b1, 2'b00, 1'b0, '0, 1'b0);
    drive(2'b00, 8'd0, '0, '0, 1'b0, 2'b01, 1'b0, '0, 1'b0);
    check("ecc.flag", 71'(be.io_ic_eccerr), 71'(2'b01));
    check("ecc.rd", 71'(be.io_ic_rd_data),
          71'(64'h1357_9BDF_2468_8CE0));
    check("ecc.noflag_par", 71'(bp.io_ic_eccerr), 71'(0));

    wexp = mm[1][5];
    drive(2'b00, 8'd5, '0, '0, 1'b1, 2'b00, 1'b0, '0, 1'b0);
    bp.io_ic_debug_rd_en = 1'b1;
    bp.io_ic_debug_addr = 8'd5;
    bp.io_ic_debug_way = 2'b10;
    drive(2'b00, 8'd5, '0, '0, 1'b1, 2'b00, 1'b0, '0, 1'b0);
    drive(2'b00, 8'd5, '0, '0, 1'b1, 2'b00, 1'b0, '0, 1'b0);
    for (int k = 3; k <= 7; k++) begin
      idle_cyc();
      check($sformatf("dbgrd.valid.c%0d", k),
            71'(bp.io_ic_debug_rd_valid), 71'(k == 5));
      if (k == 5)
        check("dbgrd.data", bp.io_ic_debug_rd_data, wexp);
    end

    xd = par_word(64'hCAFE_F00D_8765_4321);
    idle_cyc();
    bp.io_ic_debug_wr_en = 1'b1;
    bp.io_ic_debug_addr = 8'd20;
    bp.io_ic_debug_way = 2'b01;
    bp.io_ic_debug_wr_data = xd;
    mm[0][20] = xd;
    idle_cyc();
    drive(2'b00, 8'd20, '0, '0, 1'b1, 2'b00, 1'b0, '0, 1'b0);
    drive(2'b00, 8'd0, '0, '0, 1'b0, 2'b01, 1'b0, '0, 1'b0);
    check("dbgwr.rd", 71'(bp.io_ic_rd_data),
          71'(64'hCAFE_F00D_8765_4321));

    idle_cyc();
    bp.io_ic_debug_rd_en = 1'b1;
    bp.io_ic_debug_addr = 8'd20;
    bp.io_ic_debug_way = 2'b01;
    got = 0;
    for (int k = 0; k < 10; k++) begin
      idle_cyc();
      if (bp.io_ic_debug_rd_valid) begin
        got = 1;
        check("dbgrt.data", bp.io_ic_debug_rd_data, xd);
        break;
      end
    end
    check("dbgrt.seen", 71'(got), 71'(1));

    for (int i = 0; i < 400; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 9) == 0) ? 8'd255 :
          8'($urandom_range(0, 7));
      drive(($urandom_range(0, 2) == 0) ?
              2'($urandom) : 2'b00,
            a, rnd_word(), rnd_word(),
            1'($urandom), 2'($urandom),
            ($urandom_range(0, 4) == 0),
            {$urandom, $urandom},
            ($urandom_range(0, 3) == 0));
      check_read($sformatf("rnd%0d", i));
    end

    drive(2'b00, 8'd5, '0, '0, 1'b1, 2'b00, 1'b0, '0, 1'b0);
    bp.io_ic_debug_rd_en = 1'b1;
    bp.io_ic_debug_addr = 8'd5;
    bp.io_ic_debug_way = 2'b01;
    drive(2'b00, 8'd5, '0, '0, 1'b1, 2'b00, 1'b0, '0, 1'b0);
    rst_l = 1'b0;
    #1;
    check("midrst.busy", 71'(bp.io_ic_init_busy), 71'(1));
    check("midrst.ddata", bp.io_ic_debug_rd_data, 71'(0));
    check("midrst.rd", 71'(bp.io_ic_rd_data), 71'(0));
    zero_inputs();
    model_clear();
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    count_init(nb, nv);
    check("midrst.cycles", 71'(nb), 71'(DEPTH));
    check("midrst.novalid", 71'(nv), 71'(0));
    repeat (4) begin
      idle_cyc();
      if (bp.io_ic_debug_rd_valid) nv++;
    end
    check("midrst.novalid2", 71'(nv), 71'(0));

    drive(2'b00, 8'd20, '0, '0, 1'b1, 2'b00, 1'b0, '0, 1'b0);
    drive(2'b00, 8'd30, '0, '0, 1'b1, 2'b11, 1'b0, '0, 1'b0);
    check("reinit.rd20", 71'(bp.io_ic_rd_data), 71'(0));
    drive(2'b00, 8'd0, '0, '0, 1'b0, 2'b11, 1'b0, '0, 1'b0);
    check_read("reinit.rd30");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
